disp_colr_adapt: RTL and testbench
==================================

Name: disp_colr_adapt

Overview:
- Pixel-domain colour width adapter between the display pipeline and the board video outputs.
- Converts CHANNELS colour channels from BPC_IN to BPC_OUT bits per channel:
  - Widening uses bit replication.
  - Narrowing uses a run-time selectable truncate, round, ordered-dither or temporal-dither mode.
- Two-stage pipeline; display timing sideband is delayed to stay aligned with the colour data.

Parameters:
- BPC_IN, 5, input bits per colour channel (1..12).
- BPC_OUT, 8, output bits per colour channel (1..12).
- CHANNELS, 3, colour channel count (1..4). Channel CHANNELS-1 sits in the MSBs, e.g. RGB555 red.
- CORDW, 16, signed coordinate width (bits).

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  synchronous reset, active high.
- mode_req  in  2  requested narrowing mode: 0 truncate, 1 round, 2 ordered, 3 temporal.
- x_in  in  CORDW  signed horizontal position.
- y_in  in  CORDW  signed vertical position.
- hsync_in, vsync_in, de_in, frame_in  in  1 each  display timing; frame_in is high for one cycle at frame start.
- colr_in  in  CHANNELS*BPC_IN  packed input colour.
- x_out, y_out  out  CORDW  delayed positions.
- hsync_out, vsync_out, de_out, frame_out  out  1 each  delayed timing.
- colr_out  out  CHANNELS*BPC_OUT  packed adapted colour.
- mode_out  out  2  mode in effect for current output pixel.

Behaviour:
- Only one clock is used; the reset is synchronous and active-high.
- Latency is exactly 2 cycles for every output: input at cycle N appears at cycle N+2. There is no backpressure and no stalls.
- Reset state:
  - All outputs are 0: colour, x, y, syncs, de, frame, mode_out.
  - Internal mode register = 0.
  - Frame counter fc (2 bits) = 0.
  - Both pipeline stages are flushed to zero.
  - A reset mid-frame takes effect on the next edge; outputs resume 2 cycles after rst_pix falls.
- Mode latching:
  - mode_eff = frame_in ? mode_req : mode_q.
  - mode_q <= mode_eff every cycle.
  - Changes to mode_req mid-frame are ignored until the next frame_in.
- Frame counter: fc increments (wraps 3->0) on each cycle with frame_in=1. Stage 0 uses the value before the increment.
- Widening (BPC_OUT >= BPC_IN): each channel is the input replicated MSB-first and truncated to BPC_OUT. Mode is ignored, but mode_out still reports mode_q.
- Narrowing (D = BPC_IN - BPC_OUT > 0), per channel:
  - Threshold t depends on mode:
    - Mode 0: t = 0.
    - Mode 1: t = 1 << (D-1).
    - Mode 2: t = B[y_in[1:0]][x_in[1:0]] scaled to D bits. Scaling is >> (4-D) if D <= 4, else << (D-4).
    - Mode 3: as mode 2, but with index x' = x_in[1:0] + {fc[1],fc[0]} and y' = y_in[1:0] + {fc[0],fc[1]}, both mod 4.
  - Bayer matrix B, rows y = 0..3: {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
  - Negative coordinates use their two's-complement low bits.
  - Stage 1 registers sum = in + t, width BPC_IN+1.
  - Stage 2 outputs sum >> D, saturated to all-ones if sum[BPC_IN] is set.
- Blanking: when de_in=0, the colour input is forced to 0 before the adapt stage, so the output is 0.

Optional Feature:
- Macro: COLR_ADAPT_GREY_EN.
- When defined:
  - Adds input port grey_req (1 bit), latched alongside mode_req at frame_in.
  - When the latched value is high, luma L = (c2 + 2*c1 + c0) >> 2 (BPC_IN bits) replaces every channel before adaptation.
  - Valid only when CHANNELS==3; an elaboration error is raised otherwise.
- When undefined: no port and no logic; behaviour is exactly as above.

Decomposition:
- Package disp_colr_pkg holds:
  - the mode encodings (COLR_TRUNC, COLR_ROUND, COLR_ORDER, COLR_TEMPORAL);
  - the 16-entry Bayer constant;
  - a function scaling a 4-bit threshold to D bits.
- Sub-module: colr_chan_adapt, one per channel via generate. It handles a single channel's replicate, threshold-add and saturate across the two stages. The top level holds the timing delay, the mode latch and fc.

Test Plan:
- Widen 5->8, de=1:
  - colr_in channel 5'h1F -> 8'hFF.
  - 5'h10 -> 8'h84.
  - 5'h00 -> 8'h00.
  - frame_in pulse at cycle N -> frame_out at N+2 with x/y matching.
- Narrow 8->5, mode 0 then 1 (each latched at frame_in):
  - Mode 0: 8'hFF -> 5'h1F; 8'h07 -> 0.
  - Mode 1: 8'h04 -> 5'h01; 8'hFF saturates to 5'h1F.
- Mode 2, 8->5, constant input 8'h02 over a 4x4 block at x,y = 0..3: output is 1 exactly at the four positions with B >= 12, 0 elsewhere; x = -4..-1 gives the same pattern.
- Mode 3:
  - Same input over 4 frames: the pattern at (0,0) follows fc, and the total count of ones per 4x4 block is 4 every frame.
  - fc wraps 3->0.
- Mode change mid-frame:
  - mode_req 0->1 with frame_in low -> mode_out stays 0 until 2 cycles after the next frame_in.
  - de_in=0 -> colr_out=0.
- Reset mid-frame: assert rst_pix for 1 cycle while de=1 -> all outputs 0 from the next edge; fc=0 and mode_out=0; first valid pixel appears 2 cycles after release.

Source files
------------

// File: rtl/disp_colr_pkg.sv
// Shared encodings and constants for the display colour width adapter.
package disp_colr_pkg;

    typedef enum logic [1:0] {
        COLR_TRUNC    = 2'd0,
        COLR_ROUND    = 2'd1,
        COLR_ORDER    = 2'd2,
        COLR_TEMPORAL = 2'd3
    } colr_mode_e;

    // 4x4 ordered-dither matrix, indexed by {y[1:0], x[1:0]}
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic logic [11:0] scale_thresh(input logic [3:0] b, input int d);
        logic [11:0] w;
        w = {8'd0, b};
        if (d <= 4)
            scale_thresh = w >> (4 - d);
        else
            scale_thresh = w << (d - 4);
    endfunction

endpackage

// File: rtl/disp_colr_adapt_chan.sv
// Single colour channel: replicate when widening, threshold-add and saturate
// when narrowing. Two register stages in both cases.
module colr_chan_adapt
    import disp_colr_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  colr_mode_e         mode,
    input  logic [3:0]         bayer,
    input  logic [BPC_IN-1:0]  chan_in,
    output logic [BPC_OUT-1:0] chan_out
);

    logic [BPC_OUT-1:0] out_reg;

    assign chan_out = out_reg;

    if (BPC_OUT >= BPC_IN) begin : g_widen
        logic [BPC_OUT-1:0] rep;
        logic [BPC_OUT-1:0] rep_reg;
        wire                unused_ok = ^{mode, bayer};

        for (genvar gi = 0; gi < BPC_OUT; gi++) begin : g_rep
            assign rep[BPC_OUT-1-gi] = chan_in[BPC_IN-1-(gi % BPC_IN)];
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                rep_reg <= '0;
                out_reg <= '0;
            end else begin
                rep_reg <= rep;
                out_reg <= rep_reg;
            end
        end
    end else begin : g_narrow
        localparam int D = BPC_IN - BPC_OUT;

        logic [BPC_IN-1:0] thresh;
        logic [BPC_IN:0]   sum_reg;

        always_comb begin
            thresh = '0;
            case (mode)
                COLR_TRUNC: thresh = '0;
                COLR_ROUND: thresh = BPC_IN'(1) << (D - 1);
                default:    thresh = BPC_IN'(scale_thresh(bayer, D));
            endcase
        end

        // carry out of the add means the rounded value overflowed the output range
        always_ff @(posedge clk) begin
            if (srst) begin
                sum_reg <= '0;
                out_reg <= '0;
            end else begin
                sum_reg <= {1'b0, chan_in} + {1'b0, thresh};
                out_reg <= sum_reg[BPC_IN] ? '1 : sum_reg[BPC_IN-1:D];
            end
        end
    end

endmodule

// File: rtl/disp_colr_adapt.sv
// Colour width adapter top: mode latch, frame counter, timing delay, per-channel adapters.
// Optional greyscale path enabled by defining COLR_ADAPT_GREY_EN.
module disp_colr_adapt
    import disp_colr_pkg::*;
#(
    parameter int BPC_IN   = 5,
    parameter int BPC_OUT  = 8,
    parameter int CHANNELS = 3,
    parameter int CORDW    = 16
) (
    input  logic                         clk_pix,
    input  logic                         rst_pix,
    input  logic [1:0]                   mode_req,
`ifdef COLR_ADAPT_GREY_EN
    input  logic                         grey_req,
`endif
    input  logic signed [CORDW-1:0]      x_in,
    input  logic signed [CORDW-1:0]      y_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         de_in,
    input  logic                         frame_in,
    input  logic [CHANNELS*BPC_IN-1:0]   colr_in,
    output logic signed [CORDW-1:0]      x_out,
    output logic signed [CORDW-1:0]      y_out,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         de_out,
    output logic                         frame_out,
    output logic [CHANNELS*BPC_OUT-1:0]  colr_out,
    output logic [1:0]                   mode_out
);

    colr_mode_e mode_q_reg;
    colr_mode_e mode_eff;
    logic [1:0] fc_reg;
    logic [1:0] fc_off;
    logic [1:0] bx;
    logic [1:0] by;
    logic [3:0] bayer;

    logic [CHANNELS*BPC_IN-1:0] colr_blank;
    logic [CHANNELS*BPC_IN-1:0] colr_src;

    logic signed [CORDW-1:0] x_s1_reg, x_s2_reg, y_s1_reg, y_s2_reg;
    logic [3:0]              tim_s1_reg, tim_s2_reg;
    colr_mode_e              mode_s1_reg, mode_s2_reg;

    assign mode_eff = frame_in ? colr_mode_e'(mode_req) : mode_q_reg;

    // temporal mode walks the dither matrix origin with the frame counter
    assign fc_off = (mode_eff == COLR_TEMPORAL) ? fc_reg : 2'd0;
    assign bx     = x_in[1:0] + fc_off;
    assign by     = y_in[1:0] + {fc_off[0], fc_off[1]};
    assign bayer  = BAYER[{by, bx}];

    assign colr_blank = de_in ? colr_in : '0;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            mode_q_reg <= COLR_TRUNC;
            fc_reg     <= 2'd0;
        end else begin
            mode_q_reg <= mode_eff;
            if (frame_in)
                fc_reg <= fc_reg + 2'd1;
        end
    end

`ifdef COLR_ADAPT_GREY_EN
    if (CHANNELS != 3) begin : g_grey_chk
        $error("COLR_ADAPT_GREY_EN requires CHANNELS == 3");
    end

    logic                grey_q_reg;
    logic                grey_eff;
    logic [BPC_IN+1:0]   luma_sum;
    logic [BPC_IN-1:0]   luma;

    assign grey_eff = frame_in ? grey_req : grey_q_reg;
    assign luma_sum = {2'b00, colr_blank[2*BPC_IN +: BPC_IN]}
                    + {1'b0, colr_blank[BPC_IN +: BPC_IN], 1'b0}
                    + {2'b00, colr_blank[0 +: BPC_IN]};
    assign luma     = luma_sum[BPC_IN+1:2];
    assign colr_src = grey_eff ? {CHANNELS{luma}} : colr_blank;

    always_ff @(posedge clk_pix) begin
        if (rst_pix)
            grey_q_reg <= 1'b0;
        else
            grey_q_reg <= grey_eff;
    end
`else
    assign colr_src = colr_blank;
`endif

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            x_s1_reg    <= '0;
            y_s1_reg    <= '0;
            tim_s1_reg  <= '0;
            mode_s1_reg <= COLR_TRUNC;
            x_s2_reg    <= '0;
            y_s2_reg    <= '0;
            tim_s2_reg  <= '0;
            mode_s2_reg <= COLR_TRUNC;
        end else begin
            x_s1_reg    <= x_in;
            y_s1_reg    <= y_in;
            tim_s1_reg  <= {hsync_in, vsync_in, de_in, frame_in};
            mode_s1_reg <= mode_eff;
            x_s2_reg    <= x_s1_reg;
            y_s2_reg    <= y_s1_reg;
            tim_s2_reg  <= tim_s1_reg;
            mode_s2_reg <= mode_s1_reg;
        end
    end

    assign x_out     = x_s2_reg;
    assign y_out     = y_s2_reg;
    assign hsync_out = tim_s2_reg[3];
    assign vsync_out = tim_s2_reg[2];
    assign de_out    = tim_s2_reg[1];
    assign frame_out = tim_s2_reg[0];
    assign mode_out  = mode_s2_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        colr_chan_adapt #(
            .BPC_IN  (BPC_IN),
            .BPC_OUT (BPC_OUT)
        ) u_chan (
            .clk      (clk_pix),
            .srst     (rst_pix),
            .mode     (mode_eff),
            .bayer    (bayer),
            .chan_in  (colr_src[gi*BPC_IN +: BPC_IN]),
            .chan_out (colr_out[gi*BPC_OUT +: BPC_OUT])
        );
    end

endmodule

// File: tb/tb_disp_colr_adapt.sv
// Directed bench: one widening (5->8) and one narrowing (8->5) instance share timing inputs.
module tb_disp_colr_adapt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [1:0]         mode_req;
    logic signed [15:0] x_in, y_in;
    logic               hs, vs, de, fr;
    logic [14:0]        cw;
    logic [23:0]        cn;

    logic signed [15:0] x_out_w, y_out_w, x_out_n, y_out_n;
    logic               hs_w, vs_w, de_w, fr_w, hs_n, vs_n, de_n, fr_n;
    logic [23:0]        co_w;
    logic [14:0]        co_n;
    logic [1:0]         mo_w, mo_n;

    int checks   = 0;
    int failures = 0;

    disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANNELS(3), .CORDW(16)) dut_w (
        .clk_pix(clk), .rst_pix(rst), .mode_req(mode_req),
        .x_in(x_in), .y_in(y_in), .hsync_in(hs), .vsync_in(vs), .de_in(de), .frame_in(fr),
        .colr_in(cw),
        .x_out(x_out_w), .y_out(y_out_w), .hsync_out(hs_w), .vsync_out(vs_w),
        .de_out(de_w), .frame_out(fr_w), .colr_out(co_w), .mode_out(mo_w)
    );

    disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .CORDW(16)) dut_n (
        .clk_pix(clk), .rst_pix(rst), .mode_req(mode_req),
        .x_in(x_in), .y_in(y_in), .hsync_in(hs), .vsync_in(vs), .de_in(de), .frame_in(fr),
        .colr_in(cn),
        .x_out(x_out_n), .y_out(y_out_n), .hsync_out(hs_n), .vsync_out(vs_n),
        .de_out(de_n), .frame_out(fr_n), .colr_out(co_n), .mode_out(mo_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fr = 0; de = 0; hs = 0; vs = 0; x_in = 0; y_in = 0; cw = '0; cn = '0;
    endtask

    // one pixel followed by one idle cycle; outputs then show that pixel
    task automatic pix(input logic signed [15:0] px, input logic signed [15:0] py,
                       input logic f, input logic d, input logic [14:0] w, input logic [23:0] n);
        x_in = px; y_in = py; fr = f; de = d; hs = px[0]; vs = py[0]; cw = w; cn = n;
        step();
        idle();
        step();
    endtask

    task automatic test_reset();
        rst = 1; mode_req = 2'd3;
        x_in = 16'sd7; y_in = 16'sd9; fr = 1; de = 1; hs = 1; vs = 1; cw = 15'h7FFF; cn = 24'hFFFFFF;
        step(); step(); step();
        checks++; if (co_w !== 24'h0) begin failures++; $display("FAIL reset_colr_w got=%h exp=0", co_w); end
        checks++; if (co_n !== 15'h0) begin failures++; $display("FAIL reset_colr_n got=%h exp=0", co_n); end
        checks++; if ({x_out_w, y_out_w} !== 32'h0) begin failures++; $display("FAIL reset_xy got=%h exp=0", {x_out_w, y_out_w}); end
        checks++; if ({hs_w, vs_w, de_w, fr_w} !== 4'h0) begin failures++; $display("FAIL reset_timing got=%b exp=0000", {hs_w, vs_w, de_w, fr_w}); end
        checks++; if ({mo_w, mo_n} !== 4'h0) begin failures++; $display("FAIL reset_mode got=%b exp=0000", {mo_w, mo_n}); end
        rst = 0; idle(); mode_req = 2'd0;
        step(); step();
        $display("test_reset done");
    endtask

    task automatic test_widen();
        pix(16'sd3, 16'sd4, 0, 1, {5'h1F, 5'h10, 5'h00}, 24'h0);
        checks++; if (co_w !== {8'hFF, 8'h84, 8'h00}) begin failures++; $display("FAIL widen_a got=%h exp=ff8400", co_w); end
        pix(16'sd3, 16'sd4, 0, 1, {5'h00, 5'h1F, 5'h10}, 24'h0);
        checks++; if (co_w !== {8'h00, 8'hFF, 8'h84}) begin failures++; $display("FAIL widen_b got=%h exp=00ff84", co_w); end
        x_in = 16'sd12; y_in = -16'sd3; fr = 1; de = 1; hs = 0; vs = 1; cw = {5'h10, 5'h10, 5'h10}; cn = '0;
        step();
        checks++; if (fr_w !== 1'b0) begin failures++; $display("FAIL widen_frame_early got=%b exp=0", fr_w); end
        idle();
        step();
        checks++; if (fr_w !== 1'b1) begin failures++; $display("FAIL widen_frame got=%b exp=1", fr_w); end
        checks++; if (x_out_w !== 16'sd12 || y_out_w !== -16'sd3) begin failures++; $display("FAIL widen_xy got=%0d,%0d exp=12,-3", x_out_w, y_out_w); end
        checks++; if ({hs_w, vs_w, de_w} !== 3'b011) begin failures++; $display("FAIL widen_sync got=%b exp=011", {hs_w, vs_w, de_w}); end
        checks++; if (co_w !== 24'h848484) begin failures++; $display("FAIL widen_frame_colr got=%h exp=848484", co_w); end
        step();
        checks++; if (fr_w !== 1'b0) begin failures++; $display("FAIL widen_frame_late got=%b exp=0", fr_w); end
        $display("test_widen done");
    endtask

    task automatic test_narrow();
        mode_req = 2'd0;
        pix(16'sd0, 16'sd0, 1, 1, 15'h0, {8'hFF, 8'h07, 8'h00});
        checks++; if (co_n !== {5'h1F, 5'h00, 5'h00}) begin failures++; $display("FAIL narrow_trunc got=%h exp=7c00", co_n); end
        checks++; if (mo_n !== 2'd0) begin failures++; $display("FAIL narrow_mode0 got=%0d exp=0", mo_n); end
        mode_req = 2'd1;
        pix(16'sd0, 16'sd0, 1, 1, 15'h0, {8'h04, 8'hFF, 8'h83});
        checks++; if (co_n !== {5'h01, 5'h1F, 5'h10}) begin failures++; $display("FAIL narrow_round got=%h exp=07f0", co_n); end
        checks++; if (mo_n !== 2'd1) begin failures++; $display("FAIL narrow_mode1 got=%0d exp=1", mo_n); end
        mode_req = 2'd0;
        pix(16'sd1, 16'sd0, 0, 1, 15'h0, {8'h04, 8'h04, 8'h07});
        checks++; if (co_n !== {5'h01, 5'h01, 5'h01}) begin failures++; $display("FAIL narrow_held got=%h exp=0421", co_n); end
        $display("test_narrow done");
    endtask

    task automatic test_ordered();
        logic [15:0] mask;
        logic [14:0] exp_c;
        mask = 16'h5050;
        mode_req = 2'd2;
        pix(16'sd0, 16'sd0, 1, 1, 15'h0, 24'h020202);
        checks++; if (co_n !== 15'h0) begin failures++; $display("FAIL ordered_frame got=%h exp=0", co_n); end
        mode_req = 2'd0;
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                exp_c = mask[yy*4+xx] ? 15'h0421 : 15'h0;
                pix(16'(xx), 16'(yy), 0, 1, 15'h0, 24'h020202);
                checks++; if (co_n !== exp_c) begin failures++; $display("FAIL ordered_pos x=%0d y=%0d got=%h exp=%h", xx, yy, co_n, exp_c); end
                pix(16'(xx - 4), 16'(yy - 8), 0, 1, 15'h0, 24'h020202);
                checks++; if (co_n !== exp_c) begin failures++; $display("FAIL ordered_neg x=%0d y=%0d got=%h exp=%h", xx - 4, yy - 8, co_n, exp_c); end
            end
        end
        $display("test_ordered done");
    endtask

    task automatic test_temporal();
        logic [3:0]  seq;
        logic [14:0] exp_c;
        int          cnt;
        seq = 4'b0100;
        rst = 1; idle(); step(); rst = 0; step();
        mode_req = 2'd3;
        for (int f = 0; f < 5; f++) begin
            exp_c = seq[f % 4] ? 15'h0421 : 15'h0;
            pix(16'sd0, 16'sd0, 1, 1, 15'h0, 24'h020202);
            checks++; if (co_n !== exp_c) begin failures++; $display("FAIL temporal_origin frame=%0d got=%h exp=%h", f, co_n, exp_c); end
            cnt = 0;
            for (int yy = 0; yy < 4; yy++) begin
                for (int xx = 0; xx < 4; xx++) begin
                    pix(16'(xx), 16'(yy), 0, 1, 15'h0, 24'h020202);
                    if (co_n === 15'h0421) cnt++;
                end
            end
            checks++; if (cnt != 4) begin failures++; $display("FAIL temporal_count frame=%0d got=%0d exp=4", f, cnt); end
        end
        $display("test_temporal done");
    endtask

    task automatic test_mode_change();
        mode_req = 2'd0;
        pix(16'sd0, 16'sd0, 1, 1, 15'h0, 24'h0);
        mode_req = 2'd1;
        pix(16'sd1, 16'sd0, 0, 1, 15'h0, 24'h0);
        checks++; if ({mo_w, mo_n} !== 4'b0000) begin failures++; $display("FAIL modechg_ignored got=%b exp=0000", {mo_w, mo_n}); end
        x_in = 16'sd2; y_in = 16'sd0; fr = 1; de = 1; cw = '0; cn = '0;
        step();
        checks++; if (mo_n !== 2'd0) begin failures++; $display("FAIL modechg_early got=%0d exp=0", mo_n); end
        idle();
        step();
        checks++; if ({mo_w, mo_n} !== 4'b0101) begin failures++; $display("FAIL modechg_applied got=%b exp=0101", {mo_w, mo_n}); end
        pix(16'sd3, 16'sd0, 0, 0, 15'h7FFF, 24'hFFFFFF);
        checks++; if (co_n !== 15'h0 || co_w !== 24'h0) begin failures++; $display("FAIL blank_colr got=%h/%h exp=0/0", co_n, co_w); end
        checks++; if (de_n !== 1'b0) begin failures++; $display("FAIL blank_de got=%b exp=0", de_n); end
        $display("test_mode_change done");
    endtask

    task automatic test_reset_mid();
        x_in = 16'sd4; y_in = 16'sd1; fr = 0; de = 1; cw = 15'h7FFF; cn = 24'hFFFFFF;
        step();
        rst = 1;
        step();
        checks++; if (co_n !== 15'h0 || co_w !== 24'h0) begin failures++; $display("FAIL rstmid_colr got=%h/%h exp=0/0", co_n, co_w); end
        checks++; if ({mo_n, de_n, x_out_n} !== 19'h0) begin failures++; $display("FAIL rstmid_side got=%h exp=0", {mo_n, de_n, x_out_n}); end
        rst = 0;
        mode_req = 2'd1;
        x_in = 16'sd5; y_in = 16'sd0; fr = 0; de = 1; cw = '0; cn = {8'h08, 8'h10, 8'h18};
        step();
        checks++; if (co_n !== 15'h0 || de_n !== 1'b0) begin failures++; $display("FAIL rstmid_gap got=%h de=%b exp=0 de=0", co_n, de_n); end
        idle();
        step();
        checks++; if (co_n !== {5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL rstmid_first got=%h exp=0443", co_n); end
        checks++; if (x_out_n !== 16'sd5 || de_n !== 1'b1 || mo_n !== 2'd0) begin failures++; $display("FAIL rstmid_first_side got=x%0d de%b m%0d exp=x5 de1 m0", x_out_n, de_n, mo_n); end
        mode_req = 2'd3;
        pix(16'sd2, 16'sd1, 1, 1, 15'h0, 24'h020202);
        checks++; if (co_n !== 15'h0421) begin failures++; $display("FAIL rstmid_fc got=%h exp=0421", co_n); end
        $display("test_reset_mid done");
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; mode_req = 2'd0; idle();
        test_reset();
        test_widen();
        test_narrow();
        test_ordered();
        test_temporal();
        test_mode_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
